// File: rtl/uar_4bit.sv
// uar_4bit: 4-bit universal shift register used as a datapath staging element.
// Each cycle a 2-bit select code picks one of four synchronous modes. Vacated
// bit positions are always filled with zero, since there is no serial input.
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst_n   in   1  asynchronous active-low reset, clears q to 0000
//   d_in    in   4  parallel load data (bit 3 = MSB), used only in mode 11
//   select  in   2  00 hold, 01 shift right, 10 shift left, 11 parallel load
//   q       out  4  register contents (bit 3 = MSB), driven straight from flops
module uar_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d_in,
    input  logic [1:0] select,
    output logic [3:0] q
);

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_SHR   = 2'b01;
    localparam logic [1:0] SEL_SHL   = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    logic [3:0] r_q;
    logic [3:0] w_next;

    // This is the 4:1 mux in front of each flop.
    always_comb begin
        w_next = r_q;
        case (select)
            SEL_HOLD: w_next = r_q;
            SEL_SHR:  w_next = {1'b0, r_q[3:1]};
            SEL_SHL:  w_next = {r_q[2:0], 1'b0};
            SEL_LOAD: w_next = d_in;
            default:  w_next = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 4'b0000;
        end else begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_uar_4bit.sv
// Self-checking bench for uar_4bit. The stimulus process drives inputs on the
// falling edge and queues the q value expected after the next rising edge;
// a monitor samples q 1 time unit after every rising edge and checks it
// against the head of the queue.
module tb_uar_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] d_in;
    logic [1:0] select;
    logic [3:0] q;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];
    string      exp_name[$];

    uar_4bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_in   (d_in),
        .select (select),
        .q      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and queue the expected post-edge value.
    task automatic step(input logic [1:0] sel, input logic [3:0] d,
                        input logic [3:0] exp, input string name);
        @(negedge clk);
        select = sel;
        d_in   = d;
        exp_q.push_back(exp);
        exp_name.push_back(name);
    endtask

    task automatic check_now(input logic [3:0] exp, input string name);
        checks++;
        if (q !== exp) begin
            failures++;
            $display("FAIL %s: q=%b expected=%b at t=%0t", name, q, exp, $time);
        end
    endtask

    // Monitor / scoreboard.
    initial begin
        logic [3:0] e;
        string      n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = exp_name.pop_front();
                check_now(e, n);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, q=%b", q);
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cycles;
        select = 2'b00;
        d_in   = 4'b0000;
        rst_n  = 1'b1;
        #1;
        rst_n  = 1'b0;
        #1;
        check_now(4'b0000, "initial_async_reset");

        // Reset held across edges; inputs ignored.
        step(2'b11, 4'b1111, 4'b0000, "reset_hold_0");
        step(2'b11, 4'b1010, 4'b0000, "reset_hold_1");

        // Release at a falling edge and load on the next rising edge.
        @(negedge clk);
        rst_n  = 1'b1;
        select = 2'b11;
        d_in   = 4'b1010;
        exp_q.push_back(4'b1010);
        exp_name.push_back("seq1_load_1010");
        step(2'b10, 4'b0000, 4'b0100, "seq1_shl");
        step(2'b01, 4'b1111, 4'b0010, "seq1_shr");
        step(2'b00, 4'b1111, 4'b0010, "seq1_hold_0");
        step(2'b00, 4'b0000, 4'b0010, "seq1_hold_1");

        step(2'b11, 4'b1100, 4'b1100, "seq2_load_1100");
        step(2'b10, 4'b0000, 4'b1000, "seq2_shl");
        step(2'b00, 4'b0000, 4'b1000, "seq2_hold");
        step(2'b01, 4'b0000, 4'b0100, "seq2_shr");

        step(2'b11, 4'b1111, 4'b1111, "drain_r_load");
        step(2'b01, 4'b0000, 4'b0111, "drain_r_1");
        step(2'b01, 4'b0000, 4'b0011, "drain_r_2");
        step(2'b01, 4'b0000, 4'b0001, "drain_r_3");
        step(2'b01, 4'b0000, 4'b0000, "drain_r_4");
        step(2'b01, 4'b1111, 4'b0000, "drain_r_zero_stays");

        step(2'b11, 4'b1111, 4'b1111, "drain_l_load");
        step(2'b10, 4'b0000, 4'b1110, "drain_l_1");
        step(2'b10, 4'b0000, 4'b1100, "drain_l_2");
        step(2'b10, 4'b0000, 4'b1000, "drain_l_3");
        step(2'b10, 4'b0000, 4'b0000, "drain_l_4");
        step(2'b10, 4'b1111, 4'b0000, "drain_l_zero_stays");

        // d_in toggling must not matter outside mode 11.
        step(2'b11, 4'b0110, 4'b0110, "ign_load_0110");
        step(2'b00, 4'b1001, 4'b0110, "ign_hold_0");
        step(2'b00, 4'b0110, 4'b0110, "ign_hold_1");
        step(2'b00, 4'b1111, 4'b0110, "ign_hold_2");
        step(2'b01, 4'b0000, 4'b0011, "ign_shr_0");
        step(2'b01, 4'b1111, 4'b0001, "ign_shr_1");

        step(2'b11, 4'b0101, 4'b0101, "b2b_load_0101");
        step(2'b11, 4'b1001, 4'b1001, "b2b_load_1001");

        // Mid-cycle asynchronous reset with q=1010.
        step(2'b11, 4'b1010, 4'b1010, "pre_reset_load");
        step(2'b00, 4'b0000, 4'b1010, "pre_reset_hold");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_now(4'b0000, "midcycle_async_reset");
        step(2'b11, 4'b1111, 4'b0000, "mid_reset_hold_0");
        step(2'b10, 4'b0101, 4'b0000, "mid_reset_hold_1");
        step(2'b01, 4'b1100, 4'b0000, "mid_reset_hold_2");
        @(negedge clk);
        rst_n  = 1'b1;
        select = 2'b11;
        d_in   = 4'b0011;
        exp_q.push_back(4'b0011);
        exp_name.push_back("post_reset_load");
        step(2'b00, 4'b0000, 4'b0011, "post_reset_hold");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_queue: %0d pending expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
